wb_regstate: RTL and testbench
==============================

# wb_regstate

Architectural-state sink at the far end of the MEM/WB latch: it consumes every write-back field the latch emits and holds the resulting state. That state is the 32×32 general register file, the HI/LO pair and the LL bit. It serves the decode stage through two GPR read ports with same-cycle write-through bypass. It also presents bypassed HI/LO and LLbit values to the execute and memory stages.

## Interface
Parameters:
- REG_NUM, 32, number of GPRs; register 0 is hardwired to zero.
- DATA_W, 32, data width of GPRs, HI and LO.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  exception flush; clears LLbit.
- wb_wd  in  5  GPR write address.
- wb_wreg  in  1  GPR write enable.
- wb_wdata  in  DATA_W  GPR write data.
- wb_hi  in  DATA_W  HI write data.
- wb_lo  in  DATA_W  LO write data.
- wb_whilo  in  1  HI/LO write enable; writes both HI and LO together.
- wb_LLbit_we  in  1  LLbit write enable.
- wb_LLbit_value  in  1  LLbit write value.
- re1  in  1  read port 1 enable.
- raddr1  in  5  read port 1 address.
- rdata1  out  DATA_W  read port 1 data; combinational.
- re2  in  1  read port 2 enable.
- raddr2  in  5  read port 2 address.
- rdata2  out  DATA_W  read port 2 data; combinational.
- hi_o  out  DATA_W  current HI, bypassed.
- lo_o  out  DATA_W  current LO, bypassed.
- LLbit_o  out  1  current LLbit, bypassed.

## Operation
- Reset (rst=1, asynchronous): all GPRs, HI, LO and LLbit cleared to 0. While rst=1, rdata1, rdata2, hi_o, lo_o and LLbit_o are forced to 0.
- GPR write: on the clock edge, if wb_wreg=1 and wb_wd≠0, then gpr[wb_wd] ← wb_wdata. A write to address 0 is discarded.
- GPR read, per port n, evaluated in this priority order:
  - rst=1 → 0.
  - raddrn=0 → 0.
  - ren=0 → 0.
  - wb_wreg=1 and raddrn=wb_wd → wb_wdata (bypass).
  - Otherwise → gpr[raddrn].
- Both ports are independent; reading the same address on both ports is legal.
- HI/LO:
  - Write: on the clock edge, if wb_whilo=1 then HI ← wb_hi and LO ← wb_lo.
  - Read: hi_o = wb_whilo ? wb_hi : HI, and likewise for lo_o.
  - The upstream latch asserts wb_whilo on every unstalled cycle with pass-through values, and drives 0 with zero data on bubbles and flushes. This block must not filter that.
- LLbit:
  - Write priority on the clock edge: flush=1 → LLbit ← 0; else wb_LLbit_we=1 → LLbit ← wb_LLbit_value; else hold.
  - Read: LLbit_o = flush ? 0 : (wb_LLbit_we ? wb_LLbit_value : LLbit).
- No internal state machine; all state is registers plus bypass muxes.
- Arithmetic: none; widths pass through unchanged.

## Timing
- Write latency: one clock. A value presented on wb_* is architecturally visible in storage after the next rising edge.
- Bypass latency: zero. A reader in the same cycle as the write sees the new value combinationally, so decode never stalls on a WB hazard.
- Reset mid-operation: rst asserted between edges clears state immediately. The first write honoured is on the first rising edge after rst deasserts.
- Simultaneous events:
  - GPR write plus reads of the same address on both ports → both ports return wb_wdata.
  - flush together with wb_LLbit_we=1 → flush wins and LLbit ends at 0.
  - wb_wreg=1 with wb_wd=0 → no write and no bypass; reads of register 0 return 0.
- rdata, hi_o, lo_o and LLbit_o depend combinationally on wb_*, flush and the read inputs. There is no combinational path from these outputs back to any input.

## Test plan
- Reset and read-zero: assert rst mid-cycle after writing gpr[5]=0x1234 → rdata1 for raddr1=5 reads 0 immediately. After deassert, HI=LO=0 and LLbit_o=0.
- Write then read: write gpr[7]=0xDEADBEEF, then read port 2 at 7 next cycle → 0xDEADBEEF. Drop re2 to 0 → rdata2=0.
- Bypass: same cycle wb_wreg=1, wb_wd=9, wb_wdata=0xA5A5A5A5, with raddr1=raddr2=9 and re1=re2=1 → both ports 0xA5A5A5A5 in that cycle, and gpr[9] holds it afterwards.
- Register 0: wb_wd=0, wb_wdata=0xFFFFFFFF, wb_wreg=1 → rdata1 at raddr1=0 reads 0 in the same cycle and in every later cycle.
- HI/LO: wb_whilo=1 with wb_hi=0x11, wb_lo=0x22 → hi_o/lo_o equal 0x11/0x22 in the same cycle. Next cycle wb_whilo=0 with wb_hi=0x99 → hi_o stays 0x11.
- LLbit: wb_LLbit_we=1, value=1 → LLbit_o=1 in the same cycle and after the edge. Then flush=1 together with wb_LLbit_we=1, value=1 → LLbit_o=0 in that cycle and 0 after the edge.

Source files
------------

// File: rtl/wb_regstate.sv
// Write-back architectural state: GPR file, HI/LO and LLbit.
// Every read path bypasses the current write-back bundle combinationally.
module wb_regstate #(
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [4:0]        wb_wd,
    input  logic              wb_wreg,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              wb_whilo,
    input  logic              wb_LLbit_we,
    input  logic              wb_LLbit_value,
    input  logic              re1,
    input  logic [4:0]        raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [4:0]        raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              LLbit_o
);

    logic [DATA_W-1:0] gpr_q [REG_NUM];
    logic [DATA_W-1:0] hi_q, lo_q;
    logic              ll_q, ll_d;
    logic              gpr_we;

    assign gpr_we = wb_wreg && (wb_wd != 5'd0);

    always_comb begin
        ll_d = ll_q;
        if (flush) begin
            ll_d = 1'b0;
        end else if (wb_LLbit_we) begin
            ll_d = wb_LLbit_value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                gpr_q[i] <= '0;
            end
            hi_q <= '0;
            lo_q <= '0;
            ll_q <= 1'b0;
        end else begin
            if (gpr_we) begin
                gpr_q[wb_wd] <= wb_wdata;
            end
            if (wb_whilo) begin
                hi_q <= wb_hi;
                lo_q <= wb_lo;
            end
            ll_q <= ll_d;
        end
    end

    // Register 0 and disabled ports read as zero before any bypass match.
    always_comb begin
        rdata1 = '0;
        if (!rst && raddr1 != 5'd0 && re1) begin
            if (wb_wreg && raddr1 == wb_wd) begin
                rdata1 = wb_wdata;
            end else begin
                rdata1 = gpr_q[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (!rst && raddr2 != 5'd0 && re2) begin
            if (wb_wreg && raddr2 == wb_wd) begin
                rdata2 = wb_wdata;
            end else begin
                rdata2 = gpr_q[raddr2];
            end
        end
    end

    always_comb begin
        hi_o    = '0;
        lo_o    = '0;
        LLbit_o = 1'b0;
        if (!rst) begin
            hi_o    = wb_whilo ? wb_hi : hi_q;
            lo_o    = wb_whilo ? wb_lo : lo_q;
            LLbit_o = flush ? 1'b0
                    : (wb_LLbit_we ? wb_LLbit_value : ll_q);
        end
    end

endmodule

// File: tb/tb_wb_regstate.sv
// Self-checking bench for wb_regstate: directed cases then random traffic
// against an array-based model of the architectural state.
module tb_wb_regstate;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_whilo;
    logic        wb_LLbit_we;
    logic        wb_LLbit_value;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        LLbit_o;

    wb_regstate #(.REG_NUM(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
        .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .hi_o(hi_o), .lo_o(lo_o), .LLbit_o(LLbit_o)
    );

    always #5 clk = ~clk;

    logic [31:0] m_gpr [32];
    logic [31:0] m_hi, m_lo;
    logic        m_ll;
    int          nvec = 0;
    int          nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_gpr[i] = '0;
        m_hi = '0;
        m_lo = '0;
        m_ll = 1'b0;
    endtask

    function automatic logic [31:0] exp_rd(input logic re,
                                           input logic [4:0] a);
        if (rst || a == 5'd0 || !re) return '0;
        if (wb_wreg && a == wb_wd) return wb_wdata;
        return m_gpr[a];
    endfunction

    function automatic logic [31:0] exp_hi();
        if (rst) return '0;
        return wb_whilo ? wb_hi : m_hi;
    endfunction

    function automatic logic [31:0] exp_lo();
        if (rst) return '0;
        return wb_whilo ? wb_lo : m_lo;
    endfunction

    function automatic logic exp_ll();
        if (rst || flush) return 1'b0;
        return wb_LLbit_we ? wb_LLbit_value : m_ll;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".rd1"}, rdata1, exp_rd(re1, raddr1));
        chk({tag, ".rd2"}, rdata2, exp_rd(re2, raddr2));
        chk({tag, ".hi"}, hi_o, exp_hi());
        chk({tag, ".lo"}, lo_o, exp_lo());
        chk({tag, ".ll"}, {31'd0, LLbit_o}, {31'd0, exp_ll()});
    endtask

    task automatic tick();
        @(posedge clk);
        if (wb_wreg && wb_wd != 5'd0) m_gpr[wb_wd] = wb_wdata;
        if (wb_whilo) begin
            m_hi = wb_hi;
            m_lo = wb_lo;
        end
        if (flush) m_ll = 1'b0;
        else if (wb_LLbit_we) m_ll = wb_LLbit_value;
        #1;
    endtask

    task automatic idle();
        flush = 0; wb_wd = 0; wb_wreg = 0; wb_wdata = 0;
        wb_hi = 0; wb_lo = 0; wb_whilo = 0;
        wb_LLbit_we = 0; wb_LLbit_value = 0;
        re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
    endtask

    initial begin
        idle();
        model_clear();
        rst = 1'b1;
        #1;
        chk("rst.rd1", rdata1, 32'h0);
        chk("rst.hi", hi_o, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // reset mid-cycle clears a stored register immediately
        wb_wreg = 1; wb_wd = 5; wb_wdata = 32'h1234;
        re1 = 1; raddr1 = 5;
        #1 check_all("w5");
        tick();
        wb_wreg = 0;
        #1 chk("r5", rdata1, 32'h1234);
        rst = 1'b1;
        model_clear();
        #1 chk("rst_mid.rd1", rdata1, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst.rd1", rdata1, 32'h0);
        chk("post_rst.hi", hi_o, 32'h0);
        chk("post_rst.lo", lo_o, 32'h0);
        chk("post_rst.ll", {31'd0, LLbit_o}, 32'h0);
        tick();

        // write then read next cycle, then disable the port
        idle();
        wb_wreg = 1; wb_wd = 7; wb_wdata = 32'hDEADBEEF;
        tick();
        wb_wreg = 0; re2 = 1; raddr2 = 7;
        #1 chk("r7", rdata2, 32'hDEADBEEF);
        re2 = 0;
        #1 chk("r7_off", rdata2, 32'h0);

        // same-cycle bypass on both ports
        wb_wreg = 1; wb_wd = 9; wb_wdata = 32'hA5A5A5A5;
        re1 = 1; raddr1 = 9; re2 = 1; raddr2 = 9;
        #1;
        chk("byp.rd1", rdata1, 32'hA5A5A5A5);
        chk("byp.rd2", rdata2, 32'hA5A5A5A5);
        tick();
        wb_wreg = 0;
        #1 chk("byp_after", rdata1, 32'hA5A5A5A5);

        // register 0 is never written nor bypassed
        wb_wreg = 1; wb_wd = 0; wb_wdata = 32'hFFFFFFFF;
        raddr1 = 0; raddr2 = 0;
        #1 chk("r0_same", rdata1, 32'h0);
        tick();
        wb_wreg = 0;
        #1 chk("r0_later", rdata1, 32'h0);

        // HI/LO bypass then hold
        wb_whilo = 1; wb_hi = 32'h11; wb_lo = 32'h22;
        #1;
        chk("hl.hi", hi_o, 32'h11);
        chk("hl.lo", lo_o, 32'h22);
        tick();
        wb_whilo = 0; wb_hi = 32'h99;
        #1;
        chk("hl_hold.hi", hi_o, 32'h11);
        chk("hl_hold.lo", lo_o, 32'h22);

        // LLbit set, then flush dominates a concurrent set
        wb_LLbit_we = 1; wb_LLbit_value = 1;
        #1 chk("ll_set", {31'd0, LLbit_o}, 32'h1);
        tick();
        wb_LLbit_we = 0;
        #1 chk("ll_held", {31'd0, LLbit_o}, 32'h1);
        flush = 1; wb_LLbit_we = 1; wb_LLbit_value = 1;
        #1 chk("ll_flush", {31'd0, LLbit_o}, 32'h0);
        tick();
        idle();
        #1 chk("ll_after", {31'd0, LLbit_o}, 32'h0);

        // random traffic, small address pool to provoke hits
        for (int n = 0; n < 400; n++) begin
            wb_wreg = $urandom_range(0, 1);
            wb_wd = ($urandom_range(0, 3) == 0) ? 5'($urandom)
                                                : 5'($urandom_range(0, 6));
            wb_wdata = $urandom;
            wb_whilo = $urandom_range(0, 1);
            wb_hi = $urandom;
            wb_lo = $urandom;
            wb_LLbit_we = $urandom_range(0, 1);
            wb_LLbit_value = $urandom_range(0, 1);
            flush = ($urandom_range(0, 7) == 0);
            re1 = ($urandom_range(0, 5) != 0);
            re2 = ($urandom_range(0, 5) != 0);
            raddr1 = 5'($urandom_range(0, 6));
            raddr2 = ($urandom_range(0, 1) == 0) ? raddr1
                                                 : 5'($urandom);
            #1 check_all("rnd");
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1;
                model_clear();
                #1 check_all("rnd_rst");
                @(negedge clk);
                rst = 1'b0;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
